// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared definitions for the ID-stage hazard controller: the encoding of
//   the ID branch-type field and the controller FSM state type.
//   No ports; imported with "import hazard_pkg::*;".
package hazard_pkg;

  // ID branch-type field encodings
  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_JUMP = 3'b011;  // j / jal, target from immediate
  localparam logic [2:0] BR_JREG = 3'b100;  // jr / jalr, target from rs

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_DRAIN      = 2'd2,
    ST_HALTED     = 2'd3
  } state_e;

endpackage

// File: rtl/branch_forward_mux.sv
// branch_forward_mux
//   Selects the freshest value of one ID source operand for branch
//   resolution. The EX result wins over the MEM write-back value, which
//   wins over the register file. A load in EX cannot forward, because its
//   data does not exist yet.
// Ports:
//   i_reg                          source register index read in ID
//   i_ex_rd / i_mem_rd             destination registers in EX / MEM
//   i_ex_regwrite / i_mem_regwrite write-back enables in EX / MEM
//   i_ex_memread                   EX instruction is a load
//   i_rf_data                      register-file read value
//   i_alu_data / i_mem_data        EX ALU result / MEM write-back value
//   o_data                         forwarded operand
module branch_forward_mux #(
  parameter int unsigned N_BITS     = 32,
  parameter int unsigned N_BITS_REG = 5
) (
  input  logic [N_BITS_REG-1:0] i_reg,
  input  logic [N_BITS_REG-1:0] i_ex_rd,
  input  logic [N_BITS_REG-1:0] i_mem_rd,
  input  logic                  i_ex_regwrite,
  input  logic                  i_mem_regwrite,
  input  logic                  i_ex_memread,
  input  logic [N_BITS-1:0]     i_rf_data,
  input  logic [N_BITS-1:0]     i_alu_data,
  input  logic [N_BITS-1:0]     i_mem_data,
  output logic [N_BITS-1:0]     o_data
);

  logic regNonZero;
  logic exHit;
  logic memHit;

  // r0 is hard-wired to zero, so a write to it must never be forwarded
  always_comb begin
    regNonZero = (i_reg != '0);
    exHit  = i_ex_regwrite && !i_ex_memread && (i_ex_rd == i_reg) && regNonZero;
    memHit = i_mem_regwrite && (i_mem_rd == i_reg) && regNonZero;
    if (exHit) begin
      o_data = i_alu_data;
    end else if (memHit) begin
      o_data = i_mem_data;
    end else begin
      o_data = i_rf_data;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// hazard_controller
//   ID-stage hazard unit: resolves branches/jumps in ID using forwarded
//   operands, inserts LOAD_STALL_CYCLES bubbles per load-use hazard, drains
//   the pipeline after HALT, honours the debug step mode and keeps saturating
//   stall/flush event counters.
// Ports:
//   i_clk, i_reset (async, active-low)
//   i_branch, i_halt_id, i_rs, i_rt, i_uses_rt        ID instruction info
//   i_ex_rd, i_mem_rd, i_ex_regwrite, i_mem_regwrite,
//   i_ex_memread                                      EX/MEM destinations
//   i_dato_leido_1/2, i_dato_salida_alu/mem           operand sources
//   i_jump_direction, i_pc_plus4                      PC candidates
//   i_step_mode, i_step, i_cnt_clear                  debug unit controls
//   o_pipe_enable, o_stall, o_bubble, o_flush         pipeline control
//   o_pc_next, o_halted, o_stall_count, o_flush_count results / status
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned N_BITS            = 32,
  parameter int unsigned N_BITS_REG        = 5,
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned DRAIN_CYCLES      = 3,
  parameter int unsigned CNT_BITS          = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [2:0]            i_branch,
  input  logic                  i_halt_id,
  input  logic [N_BITS_REG-1:0] i_rs,
  input  logic [N_BITS_REG-1:0] i_rt,
  input  logic                  i_uses_rt,
  input  logic [N_BITS_REG-1:0] i_ex_rd,
  input  logic [N_BITS_REG-1:0] i_mem_rd,
  input  logic                  i_ex_regwrite,
  input  logic                  i_mem_regwrite,
  input  logic                  i_ex_memread,
  input  logic [N_BITS-1:0]     i_dato_leido_1,
  input  logic [N_BITS-1:0]     i_dato_leido_2,
  input  logic [N_BITS-1:0]     i_dato_salida_alu,
  input  logic [N_BITS-1:0]     i_dato_salida_mem,
  input  logic [N_BITS-1:0]     i_jump_direction,
  input  logic [N_BITS-1:0]     i_pc_plus4,
  input  logic                  i_step_mode,
  input  logic                  i_step,
  input  logic                  i_cnt_clear,
  output logic                  o_pipe_enable,
  output logic                  o_stall,
  output logic                  o_bubble,
  output logic                  o_flush,
  output logic [N_BITS-1:0]     o_pc_next,
  output logic                  o_halted,
  output logic [CNT_BITS-1:0]   o_stall_count,
  output logic [CNT_BITS-1:0]   o_flush_count
);

  // Down-counter wide enough for the longer of the two multi-cycle sequences
  localparam int unsigned MAX_CNT = (LOAD_STALL_CYCLES > DRAIN_CYCLES) ?
                                    LOAD_STALL_CYCLES : DRAIN_CYCLES;
  localparam int unsigned CW = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT + 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CNT_BITS-1:0]   stallCnt_q, flushCnt_q;

  logic [N_BITS-1:0]     opA, opB;
  logic                  hazard;
  logic                  takeRedirect;
  logic [N_BITS-1:0]     target;
  logic                  pipeEnable;
  logic                  stall, bubble, flush;
  logic [N_BITS-1:0]     pcNext;

  branch_forward_mux #(.N_BITS(N_BITS), .N_BITS_REG(N_BITS_REG)) u_fwd_a (
    .i_reg          (i_rs),
    .i_ex_rd        (i_ex_rd),
    .i_mem_rd       (i_mem_rd),
    .i_ex_regwrite  (i_ex_regwrite),
    .i_mem_regwrite (i_mem_regwrite),
    .i_ex_memread   (i_ex_memread),
    .i_rf_data      (i_dato_leido_1),
    .i_alu_data     (i_dato_salida_alu),
    .i_mem_data     (i_dato_salida_mem),
    .o_data         (opA)
  );

  branch_forward_mux #(.N_BITS(N_BITS), .N_BITS_REG(N_BITS_REG)) u_fwd_b (
    .i_reg          (i_rt),
    .i_ex_rd        (i_ex_rd),
    .i_mem_rd       (i_mem_rd),
    .i_ex_regwrite  (i_ex_regwrite),
    .i_mem_regwrite (i_mem_regwrite),
    .i_ex_memread   (i_ex_memread),
    .i_rf_data      (i_dato_leido_2),
    .i_alu_data     (i_dato_salida_alu),
    .i_mem_data     (i_dato_salida_mem),
    .o_data         (opB)
  );

  // Load-use hazard detection and branch/jump decision
  always_comb begin
    hazard = i_ex_memread && (i_ex_rd != '0) &&
             ((i_ex_rd == i_rs) || (i_uses_rt && (i_ex_rd == i_rt)));
    takeRedirect = 1'b0;
    target       = i_jump_direction;
    case (i_branch)
      BR_BEQ:  takeRedirect = (opA == opB);
      BR_BNE:  takeRedirect = (opA != opB);
      BR_JUMP: takeRedirect = 1'b1;
      BR_JREG: begin
        takeRedirect = 1'b1;
        target       = opA;
      end
      default: takeRedirect = 1'b0;
    endcase
  end

  // FSM next state and pipeline controls. A disabled cycle (step mode
  // without a step pulse, or halted) freezes the FSM and kills all controls.
  always_comb begin
    pipeEnable = (state_q == ST_HALTED) ? 1'b0 : (i_step_mode ? i_step : 1'b1);
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    bubble  = 1'b0;
    flush   = 1'b0;
    pcNext  = i_pc_plus4;
    case (state_q)
      ST_RUN: begin
        if (hazard) begin
          stall  = 1'b1;
          bubble = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            state_d = ST_LOAD_STALL;
            cnt_d   = CW'(LOAD_STALL_CYCLES - 1);
          end
        end else if (i_halt_id) begin
          state_d = ST_DRAIN;
          cnt_d   = CW'(DRAIN_CYCLES);
        end else if (takeRedirect) begin
          flush  = 1'b1;
          pcNext = target;
        end
      end
      ST_LOAD_STALL: begin
        stall  = 1'b1;
        bubble = 1'b1;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        stall  = 1'b1;
        bubble = 1'b1;
        cnt_d  = cnt_q - CW'(1);
        // Leaving on the last count makes o_halted rise DRAIN_CYCLES+1
        // enabled edges after HALT is accepted
        if (cnt_q <= CW'(1)) begin
          state_d = ST_HALTED;
          cnt_d   = '0;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
    if (!pipeEnable) begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall   = 1'b0;
      bubble  = 1'b0;
      flush   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Saturating event counters; clear wins over increment and is honoured
  // even while the pipeline is frozen
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else if (i_cnt_clear) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      if (bubble && (stallCnt_q != '1)) begin
        stallCnt_q <= stallCnt_q + CNT_BITS'(1);
      end
      if (flush && (flushCnt_q != '1)) begin
        flushCnt_q <= flushCnt_q + CNT_BITS'(1);
      end
    end
  end

  assign o_pipe_enable = pipeEnable;
  assign o_stall       = stall;
  assign o_bubble      = bubble;
  assign o_flush       = flush;
  assign o_pc_next     = pcNext;
  assign o_halted      = (state_q == ST_HALTED);
  assign o_stall_count = stallCnt_q;
  assign o_flush_count = flushCnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller
//   Directed scoreboard bench for hazard_controller (LOAD_STALL_CYCLES=2,
//   DRAIN_CYCLES=3, 3-bit counters so saturation is reachable). Each
//   stimulus cycle pushes its hand-computed expected outputs; a monitor
//   pops and compares them on the falling clock edge.
module tb_hazard_controller;

  typedef struct packed {
    logic        st;
    logic        bu;
    logic        fl;
    logic        en;
    logic        ha;
    logic [31:0] pc;
    logic [2:0]  sc;
    logic [2:0]  fc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [2:0]  branch;
  logic        haltId;
  logic [4:0]  rs, rt, exRd, memRd;
  logic        usesRt, exRegwrite, memRegwrite, exMemread;
  logic [31:0] rf1, rf2, aluData, memData, jumpDir, pcPlus4;
  logic        stepMode, step, cntClear;
  logic        pipeEnable, stall, bubble, flush, halted;
  logic [31:0] pcNext;
  logic [2:0]  stallCount, flushCount;

  exp_t  expQ[$];
  string nameQ[$];
  int    checks = 0;
  int    errors = 0;

  hazard_controller #(
    .N_BITS(32), .N_BITS_REG(5), .LOAD_STALL_CYCLES(2),
    .DRAIN_CYCLES(3), .CNT_BITS(3)
  ) dut (
    .i_clk(clk), .i_reset(rstN), .i_branch(branch), .i_halt_id(haltId),
    .i_rs(rs), .i_rt(rt), .i_uses_rt(usesRt), .i_ex_rd(exRd), .i_mem_rd(memRd),
    .i_ex_regwrite(exRegwrite), .i_mem_regwrite(memRegwrite),
    .i_ex_memread(exMemread), .i_dato_leido_1(rf1), .i_dato_leido_2(rf2),
    .i_dato_salida_alu(aluData), .i_dato_salida_mem(memData),
    .i_jump_direction(jumpDir), .i_pc_plus4(pcPlus4),
    .i_step_mode(stepMode), .i_step(step), .i_cnt_clear(cntClear),
    .o_pipe_enable(pipeEnable), .o_stall(stall), .o_bubble(bubble),
    .o_flush(flush), .o_pc_next(pcNext), .o_halted(halted),
    .o_stall_count(stallCount), .o_flush_count(flushCount)
  );

  always #5 clk = ~clk;

  task automatic setIdle();
    branch = 3'b000; haltId = 1'b0; rs = 5'd0; rt = 5'd0; usesRt = 1'b0;
    exRd = 5'd0; memRd = 5'd0; exRegwrite = 1'b0; memRegwrite = 1'b0;
    exMemread = 1'b0; rf1 = 32'd0; rf2 = 32'd0; aluData = 32'd0;
    memData = 32'd0; jumpDir = 32'h1000; pcPlus4 = 32'h4;
    stepMode = 1'b0; step = 1'b0; cntClear = 1'b0;
  endtask

  // Queue the expected outputs for the current input cycle, then move on
  // to one time unit after the next rising edge
  task automatic applyStimulus(input string name, input logic st, input logic bu,
                               input logic fl, input logic en, input logic ha,
                               input logic [31:0] pc, input logic [2:0] sc,
                               input logic [2:0] fc);
    exp_t e;
    e = '{st: st, bu: bu, fl: fl, en: en, ha: ha, pc: pc, sc: sc, fc: fc};
    expQ.push_back(e);
    nameQ.push_back(name);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string cyc, input string fld,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s.%s: got 0x%0h, expected 0x%0h", cyc, fld, act, exp);
    end
  endtask

  // Monitor: compares every queued expectation mid-cycle
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        n = nameQ.pop_front();
        checkOutput(n, "stall",      {31'd0, stall},      {31'd0, e.st});
        checkOutput(n, "bubble",     {31'd0, bubble},     {31'd0, e.bu});
        checkOutput(n, "flush",      {31'd0, flush},      {31'd0, e.fl});
        checkOutput(n, "pipeEnable", {31'd0, pipeEnable}, {31'd0, e.en});
        checkOutput(n, "halted",     {31'd0, halted},     {31'd0, e.ha});
        checkOutput(n, "pcNext",     pcNext,              e.pc);
        checkOutput(n, "stallCount", {29'd0, stallCount}, {29'd0, e.sc});
        checkOutput(n, "flushCount", {29'd0, flushCount}, {29'd0, e.fc});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus
  initial begin
    setIdle();
    repeat (2) @(posedge clk);
    #1;
    //             name        st bu fl en ha pc        sc fc
    applyStimulus("reset",     0, 0, 0, 1, 0, 32'h4,    0, 0);
    rstN = 1'b1;
    applyStimulus("idle",      0, 0, 0, 1, 0, 32'h4,    0, 0);

    // lw r2 in EX, add r3,r2,r4 in ID
    exMemread = 1; exRegwrite = 1; exRd = 5'd2; rs = 5'd2; rt = 5'd4; usesRt = 1;
    applyStimulus("luHazard",  1, 1, 0, 1, 0, 32'h4,    0, 0);
    exMemread = 0; exRegwrite = 0; exRd = 5'd0;
    applyStimulus("luStall2",  1, 1, 0, 1, 0, 32'h4,    1, 0);
    memRd = 5'd2; memRegwrite = 1;
    applyStimulus("luResume",  0, 0, 0, 1, 0, 32'h4,    2, 0);

    // beq r1,r5: r1 forwarded from EX (7), r5 from MEM (7)
    setIdle();
    branch = 3'b001; rs = 5'd1; rt = 5'd5; usesRt = 1; rf1 = 32'd3; rf2 = 32'd9;
    exRd = 5'd1; exRegwrite = 1; aluData = 32'd7;
    memRd = 5'd5; memRegwrite = 1; memData = 32'd7;
    applyStimulus("beqTaken",  0, 0, 1, 1, 0, 32'h1000, 2, 0);
    setIdle();
    applyStimulus("afterBeq",  0, 0, 0, 1, 0, 32'h4,    2, 1);

    // bne r1,r1 never taken
    branch = 3'b010; rs = 5'd1; rt = 5'd1; usesRt = 1; rf1 = 32'd5; rf2 = 32'd5;
    applyStimulus("bneEqual",  0, 0, 0, 1, 0, 32'h4,    2, 1);

    // jr r31: EX copy (0x80) beats MEM copy (0x40) and register file
    setIdle();
    branch = 3'b100; rs = 5'd31; rf1 = 32'h10;
    exRd = 5'd31; exRegwrite = 1; aluData = 32'h80;
    memRd = 5'd31; memRegwrite = 1; memData = 32'h40;
    applyStimulus("jrFwdEx",   0, 0, 1, 1, 0, 32'h80,   2, 1);

    setIdle();
    branch = 3'b011; jumpDir = 32'h2000;
    applyStimulus("jump",      0, 0, 1, 1, 0, 32'h2000, 2, 2);

    // jump with load-use hazard: stall first, jump resolved afterwards
    exMemread = 1; exRegwrite = 1; exRd = 5'd3; rs = 5'd3;
    applyStimulus("jmpHazard", 1, 1, 0, 1, 0, 32'h4,    2, 3);
    exMemread = 0; exRegwrite = 0; exRd = 5'd0;
    applyStimulus("jmpStall2", 1, 1, 0, 1, 0, 32'h4,    3, 3);
    memRd = 5'd3; memRegwrite = 1;
    applyStimulus("jmpAfter",  0, 0, 1, 1, 0, 32'h2000, 4, 3);

    // load to r0 is never a hazard
    setIdle();
    exMemread = 1; exRegwrite = 1; exRd = 5'd0; rs = 5'd0; rt = 5'd0; usesRt = 1;
    applyStimulus("lwR0",      0, 0, 0, 1, 0, 32'h4,    4, 4);
    setIdle();
    cntClear = 1;
    applyStimulus("cntClear",  0, 0, 0, 1, 0, 32'h4,    4, 4);
    cntClear = 0;
    applyStimulus("cleared",   0, 0, 0, 1, 0, 32'h4,    0, 0);

    // step mode: one step pulse during the 2-cycle stall advances by one
    stepMode = 1; step = 0;
    exMemread = 1; exRegwrite = 1; exRd = 5'd2; rs = 5'd2;
    applyStimulus("stepWait",  0, 0, 0, 0, 0, 32'h4,    0, 0);
    step = 1;
    applyStimulus("stepHaz",   1, 1, 0, 1, 0, 32'h4,    0, 0);
    step = 0; exMemread = 0; exRegwrite = 0; exRd = 5'd0;
    applyStimulus("stepFroze", 0, 0, 0, 0, 0, 32'h4,    1, 0);
    step = 1;
    applyStimulus("stepLs",    1, 1, 0, 1, 0, 32'h4,    1, 0);
    setIdle();
    applyStimulus("stepDone",  0, 0, 0, 1, 0, 32'h4,    2, 0);

    // four more load-use pairs drive the 3-bit stall counter into saturation
    for (int i = 0; i < 4; i++) begin
      logic [2:0] shownA, shownB;
      shownA = (i == 3) ? 3'd7 : 3'(2 + 2 * i);
      shownB = (i == 3) ? 3'd7 : 3'(3 + 2 * i);
      setIdle();
      exMemread = 1; exRegwrite = 1; exRd = 5'd6; rt = 5'd6; usesRt = 1;
      applyStimulus("satHazard", 1, 1, 0, 1, 0, 32'h4,  shownA, 0);
      exMemread = 0; exRegwrite = 0; exRd = 5'd0;
      applyStimulus("satStall2", 1, 1, 0, 1, 0, 32'h4,  shownB, 0);
    end
    setIdle();
    applyStimulus("saturated", 0, 0, 0, 1, 0, 32'h4,    7, 0);
    cntClear = 1;
    applyStimulus("clear2",    0, 0, 0, 1, 0, 32'h4,    7, 0);
    cntClear = 0;

    // HALT drain: halted on the 4th edge after acceptance
    haltId = 1;
    applyStimulus("haltAccept",0, 0, 0, 1, 0, 32'h4,    0, 0);
    haltId = 0;
    applyStimulus("drain1",    1, 1, 0, 1, 0, 32'h4,    0, 0);
    applyStimulus("drain2",    1, 1, 0, 1, 0, 32'h4,    1, 0);
    applyStimulus("drain3",    1, 1, 0, 1, 0, 32'h4,    2, 0);
    branch = 3'b011; jumpDir = 32'h3000;
    applyStimulus("halted1",   0, 0, 0, 0, 1, 32'h4,    3, 0);
    branch = 3'b000;
    applyStimulus("halted2",   0, 0, 0, 0, 1, 32'h4,    3, 0);

    // async reset leaves HALTED
    rstN = 1'b0;
    applyStimulus("rstHalted", 0, 0, 0, 1, 0, 32'h4,    0, 0);
    rstN = 1'b1;
    applyStimulus("postRst",   0, 0, 0, 1, 0, 32'h4,    0, 0);

    // reset in the middle of a load stall returns to RUN at once
    exMemread = 1; exRegwrite = 1; exRd = 5'd2; rs = 5'd2;
    applyStimulus("rsHazard",  1, 1, 0, 1, 0, 32'h4,    0, 0);
    exMemread = 0; exRegwrite = 0; exRd = 5'd0;
    rstN = 1'b0;
    applyStimulus("rsInReset", 0, 0, 0, 1, 0, 32'h4,    0, 0);
    rstN = 1'b1;
    applyStimulus("rsRun",     0, 0, 0, 1, 0, 32'h4,    0, 0);

    for (int k = 0; k < 5 && expQ.size() > 0; k++) @(negedge clk);
    if (expQ.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
